// File: rtl/cpu4_pkg.sv
// Shared ISA constants for the 4-bit CPU: opcodes, sequencer state codes, ALU codes and
// the decoded instruction classes used by the control unit and the disassembler monitor.
package cpu4_pkg;
  localparam int OP_WIDTH = 4;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_JZ  = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // EX3 shares its low 3 bits with EX2 so the 3-bit debug port can carry HALT as 3'b111.
  localparam logic [3:0] ST_IDLE    = 4'b0000;
  localparam logic [3:0] ST_FETCH   = 4'b0001;
  localparam logic [3:0] ST_READ    = 4'b0010;
  localparam logic [3:0] ST_LOAD_IR = 4'b0011;
  localparam logic [3:0] ST_DECODE  = 4'b0100;
  localparam logic [3:0] ST_EX1     = 4'b0101;
  localparam logic [3:0] ST_EX2     = 4'b0110;
  localparam logic [3:0] ST_EX3     = 4'b1110;
  localparam logic [3:0] ST_HALT    = 4'b0111;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [3:0] {
    CL_NOP, CL_LDA, CL_ADD, CL_SUB, CL_OUT, CL_JMP, CL_JZ, CL_HLT, CL_ILL
  } op_class_e;

  typedef enum logic [1:0] {EX_ACC, EX_JMP, EX_SKIP, EX_OUT} ex_kind_e;

  typedef struct packed {
    ex_kind_e   kind;
    logic [1:0] alu_op;
  } ex_ctl_t;

  typedef struct packed {
    logic       ir_load;
    logic       mar_load;
    logic       mem_rd;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       out_load;
    logic       halt;
  } ctl_t;
endpackage

// File: rtl/control_unit_if.sv
// Control-unit bundle: run/step/opcode/flag in, datapath strobes and debug state out.
interface control_unit_if #(parameter int OP_W = 4);
  logic            run_i;
  logic            step_i;
  logic [OP_W-1:0] ri_i;
  logic            z_i;
  logic            ir_load_o;
  logic            mar_load_o;
  logic            mem_rd_o;
  logic            pc_inc_o;
  logic            pc_load_o;
  logic            acc_load_o;
  logic [1:0]      alu_op_o;
  logic            out_load_o;
  logic            halt_o;
  logic [2:0]      state_o;

  modport master (
    output run_i, step_i, ri_i, z_i,
    input  ir_load_o, mar_load_o, mem_rd_o, pc_inc_o, pc_load_o, acc_load_o,
           alu_op_o, out_load_o, halt_o, state_o
  );
  modport slave (
    input  run_i, step_i, ri_i, z_i,
    output ir_load_o, mar_load_o, mem_rd_o, pc_inc_o, pc_load_o, acc_load_o,
           alu_op_o, out_load_o, halt_o, state_o
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational opcode -> instruction-class decode; shared with the disassembler monitor.
module cu_decode
  import cpu4_pkg::*;
(
  input  logic [OP_WIDTH-1:0] op,
  output op_class_e           cls
);
  always_comb begin
    cls = CL_ILL;
    case (op)
      OP_NOP: cls = CL_NOP;
      OP_LDA: cls = CL_LDA;
      OP_ADD: cls = CL_ADD;
      OP_SUB: cls = CL_SUB;
      OP_OUT: cls = CL_OUT;
      OP_JMP: cls = CL_JMP;
      OP_JZ:  cls = CL_JZ;
      OP_HLT: cls = CL_HLT;
      default: cls = CL_ILL;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer; strobes are registered from the next state.
// Define CU_STEP_EN for single-step mode (one instruction per rising edge of step_i).
module control_unit
  import cpu4_pkg::*;
#(
  parameter int OP_W         = OP_WIDTH,
  parameter int ILLEGAL_HALT = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  control_unit_if.slave  bus
);
  logic [3:0]      st, ns, done_st;
  ex_ctl_t         ex, nx;
  ctl_t            ctl_d, ctl_q;
  op_class_e       cls;
  logic [OP_W-1:0] op_raw;
  logic            start;

  assign op_raw = bus.ri_i;

  cu_decode u_dec (.op(op_raw), .cls(cls));

`ifdef CU_STEP_EN
  logic step_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) step_q <= 1'b0;
    else       step_q <= bus.step_i;
  assign start   = bus.run_i & bus.step_i & ~step_q;
  assign done_st = ST_IDLE;
`else
  logic unused_step;
  assign unused_step = bus.step_i;
  assign start       = bus.run_i;
  assign done_st     = bus.run_i ? ST_FETCH : ST_IDLE;
`endif

  // ri_i/z_i are only trusted in DECODE; the execute plan is latched into ex for EX1..EX3.
  always_comb begin
    ns = st;
    nx = ex;
    case (st)
      ST_IDLE:    if (start) ns = ST_FETCH;
      ST_FETCH:   ns = ST_READ;
      ST_READ:    ns = ST_LOAD_IR;
      ST_LOAD_IR: ns = ST_DECODE;
      ST_DECODE: begin
        ns = ST_EX1;
        case (cls)
          CL_LDA: nx = '{kind: EX_ACC, alu_op: ALU_PASS};
          CL_ADD: nx = '{kind: EX_ACC, alu_op: ALU_ADD};
          CL_SUB: nx = '{kind: EX_ACC, alu_op: ALU_SUB};
          CL_OUT: nx = '{kind: EX_OUT, alu_op: ALU_PASS};
          CL_JMP: nx = '{kind: EX_JMP, alu_op: ALU_PASS};
          CL_JZ:  nx = '{kind: (bus.z_i ? EX_JMP : EX_SKIP), alu_op: ALU_PASS};
          CL_HLT: ns = ST_HALT;
          CL_ILL: ns = (ILLEGAL_HALT != 0) ? ST_HALT : done_st;
          default: ns = done_st;
        endcase
      end
      ST_EX1:  ns = (ex.kind == EX_OUT || ex.kind == EX_SKIP) ? done_st : ST_EX2;
      ST_EX2:  ns = ST_EX3;
      ST_EX3:  ns = done_st;
      ST_HALT: ns = ST_HALT;
      default: ns = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl_d = '0;
    case (ns)
      ST_FETCH:   ctl_d.mar_load = 1'b1;
      ST_READ:    begin ctl_d.mem_rd = 1'b1; ctl_d.pc_inc = 1'b1; end
      ST_LOAD_IR: ctl_d.ir_load = 1'b1;
      ST_EX1: begin
        case (nx.kind)
          EX_ACC, EX_JMP: ctl_d.mar_load = 1'b1;
          EX_SKIP:        ctl_d.pc_inc   = 1'b1;
          EX_OUT:         ctl_d.out_load = 1'b1;
          default: ;
        endcase
      end
      ST_EX2: begin
        ctl_d.mem_rd = 1'b1;
        ctl_d.pc_inc = (nx.kind == EX_ACC);
      end
      ST_EX3: begin
        if (nx.kind == EX_ACC) begin
          ctl_d.acc_load = 1'b1;
          ctl_d.alu_op   = nx.alu_op;
        end
        ctl_d.pc_load = (nx.kind == EX_JMP);
      end
      ST_HALT: ctl_d.halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st    <= ST_IDLE;
      ex    <= '{kind: EX_ACC, alu_op: ALU_PASS};
      ctl_q <= '0;
    end else begin
      st    <= ns;
      ex    <= nx;
      ctl_q <= ctl_d;
    end
  end

  assign bus.ir_load_o  = ctl_q.ir_load;
  assign bus.mar_load_o = ctl_q.mar_load;
  assign bus.mem_rd_o   = ctl_q.mem_rd;
  assign bus.pc_inc_o   = ctl_q.pc_inc;
  assign bus.pc_load_o  = ctl_q.pc_load;
  assign bus.acc_load_o = ctl_q.acc_load;
  assign bus.alu_op_o   = ctl_q.alu_op;
  assign bus.out_load_o = ctl_q.out_load;
  assign bus.halt_o     = ctl_q.halt;
  assign bus.state_o    = st[2:0];
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle {state, strobes} against hand-built tables.
module tb_control_unit;
  import cpu4_pkg::*;

  // {ir, mar, rd, inc, pc_load, acc_load, alu_op[1:0], out_load, halt}
  localparam logic [9:0] S_NONE  = 10'b0000000000;
  localparam logic [9:0] S_IR    = 10'b1000000000;
  localparam logic [9:0] S_MAR   = 10'b0100000000;
  localparam logic [9:0] S_RDINC = 10'b0011000000;
  localparam logic [9:0] S_RD    = 10'b0010000000;
  localparam logic [9:0] S_INC   = 10'b0001000000;
  localparam logic [9:0] S_PCL   = 10'b0000100000;
  localparam logic [9:0] S_LDA   = 10'b0000010000;
  localparam logic [9:0] S_ADD   = 10'b0000010100;
  localparam logic [9:0] S_SUB   = 10'b0000011000;
  localparam logic [9:0] S_OUT   = 10'b0000000010;
  localparam logic [9:0] S_HALT  = 10'b0000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  control_unit_if bus ();
  control_unit_if bus_h ();

  assign bus_h.run_i  = bus.run_i;
  assign bus_h.step_i = bus.step_i;
  assign bus_h.ri_i   = bus.ri_i;
  assign bus_h.z_i    = bus.z_i;

  control_unit u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  control_unit #(.ILLEGAL_HALT(1)) u_dut_h (.clk_i(clk), .rst_i(rst), .bus(bus_h));

  function automatic logic [12:0] obs();
    return {bus.state_o, bus.ir_load_o, bus.mar_load_o, bus.mem_rd_o, bus.pc_inc_o,
            bus.pc_load_o, bus.acc_load_o, bus.alu_op_o, bus.out_load_o, bus.halt_o};
  endfunction

  function automatic logic [12:0] obs_h();
    return {bus_h.state_o, bus_h.ir_load_o, bus_h.mar_load_o, bus_h.mem_rd_o, bus_h.pc_inc_o,
            bus_h.pc_load_o, bus_h.acc_load_o, bus_h.alu_op_o, bus_h.out_load_o, bus_h.halt_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run_i = 1'b0;
    bus.step_i = 1'b0;
    bus.z_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run_i = 1'b0; bus.step_i = 1'b0; bus.z_i = 1'b0; bus.ri_i = OP_NOP;
    #1;
    n_cmp++;
    if (obs() !== 13'd0) begin n_bad++; $display("FAIL reset_init: got %b want %b", obs(), 13'd0); end
    n_cmp++;
    if (obs_h() !== 13'd0) begin n_bad++; $display("FAIL reset_init_h: got %b want %b", obs_h(), 13'd0); end
    do_reset();
    bus.ri_i = OP_ADD; bus.run_i = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (obs() !== {3'd6, S_RDINC}) begin n_bad++; $display("FAIL reset_pre_ex2: got %b want %b", obs(), {3'd6, S_RDINC}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 13'd0) begin n_bad++; $display("FAIL reset_mid_ex2: got %b want %b", obs(), 13'd0); end
    bus.run_i = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (obs() !== 13'd0) begin n_bad++; $display("FAIL reset_stay_idle cyc%0d: got %b want %b", i, obs(), 13'd0); end
    end
  endtask

  task automatic test_lda();
    logic [12:0] exp [8];
    exp = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
            {3'd5, S_MAR}, {3'd6, S_RDINC}, {3'd6, S_LDA}, {3'd1, S_MAR}};
    do_reset();
    bus.ri_i = OP_LDA; bus.run_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL lda cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
    end
  endtask

  // run_i drops during FETCH/READ; the ADD must still finish, then park in IDLE.
  task automatic test_add_run_drop();
    logic [12:0] exp [9];
    exp = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
            {3'd5, S_MAR}, {3'd6, S_RDINC}, {3'd6, S_ADD}, {3'd0, S_NONE}, {3'd0, S_NONE}};
    do_reset();
    bus.ri_i = OP_ADD; bus.run_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 1) bus.run_i = 1'b0;
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL add_drop cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp [12];
    exp = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
            {3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
            {3'd5, S_MAR}, {3'd6, S_RDINC}, {3'd6, S_SUB}, {3'd1, S_MAR}};
    do_reset();
    bus.ri_i = OP_NOP; bus.run_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 4) bus.ri_i = OP_SUB;
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL b2b cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
    end
  endtask

  task automatic test_out();
    logic [12:0] exp [6];
    exp = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
            {3'd5, S_OUT}, {3'd1, S_MAR}};
    do_reset();
    bus.ri_i = OP_OUT; bus.run_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL out cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
    end
  endtask

  task automatic test_jz();
    logic [12:0] exp_nt [6];
    logic [12:0] exp_t [8];
    exp_nt = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
               {3'd5, S_INC}, {3'd1, S_MAR}};
    exp_t  = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
               {3'd5, S_MAR}, {3'd6, S_RD}, {3'd6, S_PCL}, {3'd1, S_MAR}};
    do_reset();
    bus.ri_i = OP_JZ; bus.z_i = 1'b0; bus.run_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp_nt[i]) begin n_bad++; $display("FAIL jz_nt cyc%0d: got %b want %b", i + 1, obs(), exp_nt[i]); end
    end
    // z_i drops after DECODE: the taken decision must already be latched.
    do_reset();
    bus.ri_i = OP_JZ; bus.z_i = 1'b1; bus.run_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) bus.z_i = 1'b0;
      n_cmp++;
      if (obs() !== exp_t[i]) begin n_bad++; $display("FAIL jz_t cyc%0d: got %b want %b", i + 1, obs(), exp_t[i]); end
    end
  endtask

  task automatic test_halt();
    logic [12:0] exp [5];
    exp = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE}, {3'd7, S_HALT}};
    do_reset();
    bus.ri_i = OP_HLT; bus.run_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL hlt cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
    end
    bus.ri_i = OP_NOP;
    for (int i = 0; i < 20; i++) begin
      bus.run_i = ~bus.run_i;
      tick();
      n_cmp++;
      if (obs() !== {3'd7, S_HALT}) begin n_bad++; $display("FAIL hlt_hold cyc%0d: got %b want %b", i, obs(), {3'd7, S_HALT}); end
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 13'd0) begin n_bad++; $display("FAIL hlt_reset: got %b want %b", obs(), 13'd0); end
    rst = 1'b0;
  endtask

  task automatic test_illegal();
    logic [12:0] exp [5];
    logic [12:0] exp_h [5];
    exp   = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE}, {3'd1, S_MAR}};
    exp_h = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE}, {3'd7, S_HALT}};
    do_reset();
    bus.ri_i = 4'b1010; bus.run_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL ill_nop cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
      n_cmp++;
      if (obs_h() !== exp_h[i]) begin n_bad++; $display("FAIL ill_halt cyc%0d: got %b want %b", i + 1, obs_h(), exp_h[i]); end
    end
  endtask

`ifdef CU_STEP_EN
  task automatic test_step();
    logic [12:0] exp [8];
    int outs;
    exp = '{{3'd1, S_MAR}, {3'd2, S_RDINC}, {3'd3, S_IR}, {3'd4, S_NONE},
            {3'd5, S_OUT}, {3'd0, S_NONE}, {3'd0, S_NONE}, {3'd0, S_NONE}};
    outs = 0;
    do_reset();
    bus.ri_i = OP_OUT; bus.run_i = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (obs() !== 13'd0) begin n_bad++; $display("FAIL step_wait: got %b want %b", obs(), 13'd0); end
    bus.step_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) bus.step_i = 1'b0;
      if (bus.out_load_o) outs++;
      n_cmp++;
      if (obs() !== exp[i]) begin n_bad++; $display("FAIL step cyc%0d: got %b want %b", i + 1, obs(), exp[i]); end
    end
    n_cmp++;
    if (outs !== 1) begin n_bad++; $display("FAIL step_outs: got %0d want 1", outs); end
    bus.step_i = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== {3'd1, S_MAR}) begin n_bad++; $display("FAIL step_next: got %b want %b", obs(), {3'd1, S_MAR}); end
    bus.step_i = 1'b0;
  endtask
`endif

  initial begin
    bus.ri_i = OP_NOP;
    test_reset();
    test_lda();
    test_add_run_drop();
    test_back_to_back();
    test_out();
    test_jz();
    test_halt();
    test_illegal();
`ifdef CU_STEP_EN
    test_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
